// File: rtl/fetch_align_buffer_pkg.sv
// Shared constants, halfword/lane types and the RVC length decode for the fetch realignment queue.
// No logic state; latency and backpressure are defined by the users of this package.
package fetch_align_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          HW_WIDTH  = 16;
  // Lane PC is carried wide enough for any supported address width and sliced by the top.
  localparam int          LANE_PC_W = 64;

  typedef logic [HW_WIDTH-1:0] hwWord_t;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          instr;
    logic [LANE_PC_W-1:0] pc;
    logic                 is16;
  } laneRec_t;

  function automatic logic is_rvc32(input hwWord_t hw);
    return hw[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_lane_extract.sv
// Combinational boundary scan: splits the halfword window at head into up to ISSUE_WIDTH instructions, zero latency.
// A lane is valid only if it and every earlier lane are complete; no flow control of its own.
module rvc_lane_extract
  import fetch_align_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ISSUE_WIDTH = 2,
  parameter int CNT_W       = 5,
  parameter int NDEQ_W      = 3
) (
  input  hwWord_t               win [2*ISSUE_WIDTH],
  input  logic [CNT_W-1:0]      count,
  input  logic [ADDR_WIDTH-1:0] headPc,
  output laneRec_t              lanes [ISSUE_WIDTH],
  output logic [NDEQ_W-1:0]     nDeq
);

  localparam int IDX_W = $clog2(2*ISSUE_WIDTH);

  int      off;
  int      avail;
  int      used;
  logic    chainVld;
  logic    wide;
  hwWord_t lo;
  hwWord_t hi;

  always_comb begin
    off      = 0;
    used     = 0;
    avail    = int'(count);
    chainVld = 1'b1;
    wide     = 1'b0;
    lo       = '0;
    hi       = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lanes[i] = '{valid: 1'b0, instr: NOP_INSTR, pc: '0, is16: 1'b0};
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lo   = win[IDX_W'(off)];
      hi   = win[IDX_W'(off + 1)];
      wide = is_rvc32(lo);
      // Presence is tested before the length decode so unwritten halfwords never open a lane.
      chainVld = chainVld && (off < avail) && (!wide || (off + 1 < avail));
      if (chainVld) begin
        lanes[i].valid = 1'b1;
        lanes[i].instr = wide ? {hi, lo} : {16'h0000, lo};
        lanes[i].pc    = LANE_PC_W'(headPc) + LANE_PC_W'(2 * off);
        lanes[i].is16  = !wide;
        used           = off + (wide ? 2 : 1);
      end
      off = off + (wide ? 2 : 1);
    end
    nDeq = NDEQ_W'(used);
  end

endmodule

// File: rtl/fetch_align_buffer.sv
// Halfword circular queue realigning fetch packets into up to ISSUE_WIDTH instructions; 1 cycle accept-to-output.
// fetch_ready needs room for a whole packet from the registered count; Decode stalls with deq_ready=0.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_BYTES = 8,
  parameter int DEPTH_HW    = 16,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [ADDR_WIDTH-1:0]         fetch_pc,
  input  logic [FETCH_BYTES*8-1:0]      fetch_data,
  input  logic                          flush,
  input  logic                          deq_ready,
  output logic [ISSUE_WIDTH-1:0]        out_valid,
  output logic [ISSUE_WIDTH*32-1:0]     out_instr,
  output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] out_pc,
  output logic [ISSUE_WIDTH-1:0]        out_16bit,
  output logic                          seq_err,
  output logic [$clog2(DEPTH_HW+1)-1:0] count
);

  localparam int PKT_HW = FETCH_BYTES / 2;
  localparam int OFF_W  = $clog2(FETCH_BYTES);
  localparam int PTR_W  = $clog2(DEPTH_HW);
  localparam int CNT_W  = $clog2(DEPTH_HW + 1);
  localparam int NDEQ_W = $clog2(2*ISSUE_WIDTH + 1);

  hwWord_t               mem [DEPTH_HW];
  hwWord_t               win [2*ISSUE_WIDTH];
  laneRec_t              lanes [ISSUE_WIDTH];
  logic [NDEQ_W-1:0]     nDeq;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [ADDR_WIDTH-1:0] headPc;
  logic [ADDR_WIDTH-1:0] expPc;
  logic                  expVld;

  logic [OFF_W-2:0]      hwOff;
  logic [ADDR_WIDTH-1:0] pktBase;
  logic [CNT_W-1:0]      nEnq;
  logic [CNT_W-1:0]      enqCnt;
  logic [CNT_W-1:0]      deqCnt;
  logic                  take;
  logic                  seqBad;
  logic                  enq;
  logic                  drop;

  assign hwOff       = fetch_pc[OFF_W-1:1];
  assign pktBase     = {fetch_pc[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign nEnq        = CNT_W'(PKT_HW) - CNT_W'(hwOff);
  assign fetch_ready = (count <= CNT_W'(DEPTH_HW - PKT_HW));

  assign take   = fetch_valid && fetch_ready && !flush;
  assign seqBad = expVld && (fetch_pc != expPc);
  assign enq    = take && !seqBad;
  assign drop   = take && seqBad;
  assign enqCnt = enq ? nEnq : '0;
  assign deqCnt = (deq_ready && lanes[0].valid) ? CNT_W'(nDeq) : '0;

  always_comb begin
    for (int k = 0; k < 2*ISSUE_WIDTH; k++) begin
      win[k] = mem[head + PTR_W'(k)];
    end
  end

  rvc_lane_extract #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ISSUE_WIDTH(ISSUE_WIDTH),
    .CNT_W      (CNT_W),
    .NDEQ_W     (NDEQ_W)
  ) uExtract (
    .win   (win),
    .count (count),
    .headPc(headPc),
    .lanes (lanes),
    .nDeq  (nDeq)
  );

  // Halfwords below the branch-target offset are skipped so the tail stays dense.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int j = 0; j < PKT_HW; j++) begin
        if (j >= int'(hwOff)) begin
          mem[tail + PTR_W'(j) - PTR_W'(hwOff)] <= fetch_data[j*16 +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      headPc  <= '0;
      expPc   <= '0;
      expVld  <= 1'b0;
      seq_err <= 1'b0;
    end else if (flush) begin
      head    <= tail;
      count   <= '0;
      expVld  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= drop;
      count   <= count + enqCnt - deqCnt;
      head    <= head + PTR_W'(deqCnt);
      if (enq) begin
        tail   <= tail + PTR_W'(nEnq);
        expPc  <= pktBase + ADDR_WIDTH'(FETCH_BYTES);
        expVld <= 1'b1;
      end
      // An empty queue cannot dequeue, so the new packet alone defines the head PC.
      if (enq && count == '0) begin
        headPc <= fetch_pc;
      end else begin
        headPc <= headPc + ADDR_WIDTH'({deqCnt, 1'b0});
      end
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : gLane
    assign out_valid[i]                        = lanes[i].valid;
    assign out_instr[i*32 +: 32]               = lanes[i].instr;
    assign out_pc[i*ADDR_WIDTH +: ADDR_WIDTH]  = lanes[i].pc[ADDR_WIDTH-1:0];
    assign out_16bit[i]                        = lanes[i].is16;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parametrised instruction realignment queue between Fetch/Icache and the dual-issue Decode.
- Accepts aligned fetch packets that may start mid-packet (branch target) and hold mixed 16-bit RVC and 32-bit instructions, including 32-bit instructions split across packets.
- Stores halfwords in a circular buffer and presents up to ISSUE_WIDTH decoded-boundary instructions per cycle, each with its PC and 16-bit flag.
- Replaces the fixed 2×32-bit IF/ID register and its Decode_NextPC feedback path.

Parameters:
- ADDR_WIDTH, 32, PC width.
- FETCH_BYTES, 8, fetch packet size in bytes; power of two, ≥4.
- DEPTH_HW, 16, buffer depth in halfwords; power of two, ≥2*FETCH_BYTES/2.
- ISSUE_WIDTH, 2, instructions presented per cycle; 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fetch_valid  in  1  fetch packet present
- fetch_ready  out  1  buffer can accept a full packet
- fetch_pc  in  ADDR_WIDTH  PC of first valid halfword; bit0 = 0
- fetch_data  in  FETCH_BYTES*8  packet, little-endian, aligned to FETCH_BYTES
- flush  in  1  discard all contents (branch or exception redirect)
- deq_ready  in  1  Decode accepts all valid lanes this cycle (0 = stall)
- out_valid  out  ISSUE_WIDTH  lane i holds a complete instruction
- out_instr  out  ISSUE_WIDTH*32  lane instructions; RVC zero-extended in [15:0]
- out_pc  out  ISSUE_WIDTH*ADDR_WIDTH  lane PCs
- out_16bit  out  ISSUE_WIDTH  lane instruction is 16-bit
- seq_err  out  1  one-cycle pulse: non-sequential packet dropped
- count  out  $clog2(DEPTH_HW+1)  occupied halfwords

Behaviour:
- Reset, when rst_n = 0 at a clk edge:
  - head, tail and count cleared; expected-PC register invalid; seq_err = 0.
  - out_valid = 0; invalid lanes drive out_instr = 32'h00000013, out_pc = 0, out_16bit = 0.
  - fetch_ready = 1 in the cycle after reset.
- fetch_ready = (DEPTH_HW - count) ≥ FETCH_BYTES/2. This is a conservative full-packet check taken from the registered count only; there is no combinational path from deq_ready.
- Enqueue fires when fetch_valid & fetch_ready & !flush:
  - Offset o = fetch_pc[$clog2(FETCH_BYTES)-1:1].
  - Halfwords o..FETCH_BYTES/2-1 are written at the tail; n_enq = FETCH_BYTES/2 - o.
  - If the buffer is empty and no bytes are in flight, head_pc <= fetch_pc.
  - expected_pc <= packet base + FETCH_BYTES.
- Sequence check:
  - If expected_pc is valid and fetch_pc ≠ expected_pc, the packet is dropped: no write, and seq_err pulses in the next cycle.
  - After reset or flush, expected_pc is invalid and the first packet is always taken.
- Lane extraction is combinational from head:
  - Lane 0 starts at head. If hw[1:0] == 2'b11 it is 32-bit and needs 2 halfwords; otherwise it is 16-bit and needs 1.
  - Lane i starts immediately after lane i-1 ends.
  - out_valid[i] = all halfwords of lane i present & out_valid[i-1].
  - out_pc[i] = head_pc + 2*(halfword offset of lane i).
- A 32-bit instruction whose upper halfword is not yet buffered gives out_valid = 0 for that lane and every later lane. It becomes valid in the cycle after the completing packet is accepted.
- Latency: 1 cycle from accept to visibility on the outputs. There is no bypass from fetch_data to the outputs.
- Dequeue when deq_ready & |out_valid:
  - n_deq = sum of halfwords of the valid lanes; head += n_deq; head_pc += 2*n_deq.
  - deq_ready with no valid lane has no effect.
- Same-cycle enqueue and dequeue: count <= count + n_enq - n_deq. The head and tail pointers wrap modulo DEPTH_HW.
- flush has highest priority:
  - Next cycle: count = 0, head = tail, expected_pc invalid, out_valid = 0.
  - The same-cycle fetch and dequeue are ignored, and seq_err is suppressed.
- Reset asserted mid-operation behaves identically to flush and also clears seq_err.
- Full: count == DEPTH_HW deasserts fetch_ready; outputs keep draining.
- Empty: out_valid = 0, and lanes drive NOP.

Decomposition:
- Shared package (with the existing Define constants):
  - NOP_INSTR = 32'h00000013.
  - HW_WIDTH = 16.
  - Function is_rvc32(hw) returning hw[1:0] == 2'b11.
  - Lane-record typedef {valid, instr, pc, is16}.
- One sub-module, rvc_lane_extract: purely combinational. Takes the halfword window at head plus count and returns the ISSUE_WIDTH lane records and n_deq. This isolates the boundary-scan logic from the pointer and PC state.

Test Plan:
- Reset, then packet pc=0x0, data=64'h00000013_00000013, deq_ready=1 → next cycle: out_valid=2'b11, out_pc={0x4,0x0}, out_16bit=0, out_instr both 0x00000013; count returns to 0.
- Packet pc=0x0, data=64'h57C157C1_57C157C1 → cycle 1: lanes 0x57C1 @0x0 and 0x57C1 @0x2, both 16-bit; cycle 2: @0x4 and @0x6; then empty with NOP.
- Split 32-bit: packet pc=0x0, data=64'h0013_57C1_57C1_57C1, deq_ready=1 → cycle 1: lanes @0x0 and @0x2 (16-bit). Cycle 2: lane @0x4 = 0x57C1, lane 1 invalid because the instruction @0x6 is 32-bit and only halfword 0x0013 is buffered. Next packet pc=0x8 data[15:0]=0x0000 → lane @0x6 = 0x00000013, valid 32-bit.
- Branch-target entry: packet pc=0x106, data[63:48]=0x4501 → n_enq=1; out_pc[0]=0x106, out_16bit[0]=1.
- Backpressure: deq_ready=0, stream sequential packets → count reaches 16 and fetch_ready=0. Then deq_ready=1 → count falls by ≥2 per cycle with no duplicated or skipped PCs.
- Flush with fetch_valid=1 in the same cycle → next cycle count=0 and out_valid=0. Packet pc=0x200 is then accepted with no seq_err. A subsequent packet pc=0x300 is dropped and seq_err pulses once.
